uart_tx_merge: RTL and testbench

- Frame-aware merger of the two serial TX streams from fpga_top (debug bridge TX, application UART TX) onto the single board UART line.
- Replaces the bitwise AND of the two lines.
- Each input is deserialised into bytes and queued in a per-source FIFO. Bytes are re-serialised one whole frame at a time, so simultaneous traffic never corrupts the line.
- Sits between fpga_top's TX outputs and the board uart_rxd_o / led_o pins.

---
 rtl/uart_tx_merge.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_uart_tx_merge.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_merge.sv
// Frame-aware merger of two 8N1 serial TX streams onto one board UART line.
// Each source is deserialised into a per-source FIFO and re-serialised one whole frame at a time.
`timescale 1ns / 1ps

module uart_tx_merge_rx #(
  parameter int BIT_DIV = 50
) (
  input  logic       clk50_i,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  localparam logic [15:0] DIV_FULL = 16'(BIT_DIV);
  localparam logic [15:0] DIV_HALF = 16'(BIT_DIV / 2);

  logic [1:0]  sync_q;
  logic        rx_s;
  logic        expire;
  rx_state_t   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        valid_d, ferr_d;

  // Idle-high line, so the synchroniser resets to 1 to avoid a false start edge.
  always_ff @(posedge clk50_i or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rxd};
  end

  assign rx_s   = sync_q[1];
  assign expire = (cnt_q == 16'd1);
  assign data   = shift_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk50_i or posedge rst) begin
    if (rst) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      valid     <= valid_d;
      frame_err <= ferr_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d = RX_START;
          cnt_d   = DIV_HALF;
        end
      end
      RX_START: begin
        if (expire) begin
          if (!rx_s) begin
            state_d = RX_DATA;
            cnt_d   = DIV_FULL;
            bit_d   = 3'd0;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      RX_DATA: begin
        if (expire) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = DIV_FULL;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      RX_STOP: begin
        if (expire) begin
          state_d = RX_IDLE;
          if (rx_s) valid_d = 1'b1;
          else      ferr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end
endmodule

module uart_tx_merge_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk50_i,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout    = mem[rd_q[AW-1:0]];
  // A pop in the same cycle frees the slot, so push-on-full is accepted then.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk50_i or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk50_i) begin
    if (do_push) mem[wr_q[AW-1:0]] <= din;
  end
endmodule

module uart_tx_merge #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUDRATE   = 1000000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk50_i,
  input  logic       rst,
  input  logic       dbg_txd_i,
  input  logic       uart_txd_i,
  output logic       txd_o,
  output logic       busy_o,
  output logic       dbg_ovf_o,
  output logic       uart_ovf_o,
  output logic [1:0] frame_err_o
);
  localparam int BIT_DIV = CLK_FREQ / BAUDRATE;
  localparam logic [15:0] DIV_FULL = 16'(BIT_DIV);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic [7:0] dbg_byte, uart_byte, dbg_dout, uart_dout;
  logic       dbg_valid, uart_valid, dbg_ferr, uart_ferr;
  logic       dbg_empty, uart_empty, dbg_full, uart_full;
  logic       pop_dbg, pop_uart, arb;

  tx_state_t   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_d;

  uart_tx_merge_rx #(.BIT_DIV(BIT_DIV)) u_dbg_rx (
    .clk50_i(clk50_i), .rst(rst), .rxd(dbg_txd_i),
    .data(dbg_byte), .valid(dbg_valid), .frame_err(dbg_ferr)
  );

  uart_tx_merge_rx #(.BIT_DIV(BIT_DIV)) u_uart_rx (
    .clk50_i(clk50_i), .rst(rst), .rxd(uart_txd_i),
    .data(uart_byte), .valid(uart_valid), .frame_err(uart_ferr)
  );

  uart_tx_merge_fifo #(.DEPTH(FIFO_DEPTH)) u_dbg_fifo (
    .clk50_i(clk50_i), .rst(rst), .push(dbg_valid), .din(dbg_byte),
    .pop(pop_dbg), .dout(dbg_dout), .empty(dbg_empty), .full(dbg_full)
  );

  uart_tx_merge_fifo #(.DEPTH(FIFO_DEPTH)) u_uart_fifo (
    .clk50_i(clk50_i), .rst(rst), .push(uart_valid), .din(uart_byte),
    .pop(pop_uart), .dout(uart_dout), .empty(uart_empty), .full(uart_full)
  );

  assign frame_err_o = {uart_ferr, dbg_ferr};

  always_ff @(posedge clk50_i or posedge rst) begin
    if (rst) begin
      state_q    <= TX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      txd_o      <= 1'b1;
      busy_o     <= 1'b0;
      dbg_ovf_o  <= 1'b0;
      uart_ovf_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      txd_o      <= txd_d;
      busy_o     <= (state_q != TX_IDLE) || !dbg_empty || !uart_empty;
      dbg_ovf_o  <= dbg_valid && dbg_full && !pop_dbg;
      uart_ovf_o <= uart_valid && uart_full && !pop_uart;
    end
  end

  // Arbitration also runs on the last stop cycle so back-to-back frames leave no idle gap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pop_dbg  = 1'b0;
    pop_uart = 1'b0;
    arb      = 1'b0;
    case (state_q)
      TX_IDLE: arb = 1'b1;
      TX_START: begin
        if (cnt_q == 16'd1) begin
          state_d = TX_DATA;
          cnt_d   = DIV_FULL;
          bit_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (cnt_q == 16'd1) begin
          cnt_d = DIV_FULL;
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (cnt_q == 16'd1) begin
          state_d = TX_IDLE;
          arb     = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = TX_IDLE;
    endcase

    if (arb) begin
      if (!dbg_empty) begin
        pop_dbg = 1'b1;
        shift_d = dbg_dout;
        state_d = TX_START;
        cnt_d   = DIV_FULL;
      end else if (!uart_empty) begin
        pop_uart = 1'b1;
        shift_d  = uart_dout;
        state_d  = TX_START;
        cnt_d    = DIV_FULL;
      end
    end

    // Line level follows the next state so txd_o changes on the same edge as the state.
    case (state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_merge.sv
// Scoreboard bench for uart_tx_merge: drivers queue expected bytes, a line monitor decodes txd_o.
`timescale 1ns / 1ps

module tb_uart_tx_merge;
  localparam int BIT_DIV = 50;

  logic       clk50_i = 1'b0;
  logic       rst = 1'b1;
  logic       dbg_txd_i = 1'b1;
  logic       uart_txd_i = 1'b1;
  logic       txd_o, busy_o, dbg_ovf_o, uart_ovf_o;
  logic [1:0] frame_err_o;

  uart_tx_merge #(.CLK_FREQ(50000000), .BAUDRATE(1000000), .FIFO_DEPTH(4)) dut (
    .clk50_i(clk50_i), .rst(rst), .dbg_txd_i(dbg_txd_i), .uart_txd_i(uart_txd_i),
    .txd_o(txd_o), .busy_o(busy_o), .dbg_ovf_o(dbg_ovf_o), .uart_ovf_o(uart_ovf_o),
    .frame_err_o(frame_err_o)
  );

  always #10 clk50_i = ~clk50_i;

  int unsigned cyc = 0;
  always @(posedge clk50_i) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  int         fall_q[$];
  bit         mon_busy = 1'b0;

  int dbg_ovf_n = 0, uart_ovf_n = 0, ferr_dbg_n = 0, ferr_uart_n = 0;
  logic [1:0] ferr_last = 2'b00;

  always @(negedge clk50_i) begin
    if (dbg_ovf_o)   dbg_ovf_n   <= dbg_ovf_n + 1;
    if (uart_ovf_o)  uart_ovf_n  <= uart_ovf_n + 1;
    if (frame_err_o[0]) ferr_dbg_n  <= ferr_dbg_n + 1;
    if (frame_err_o[1]) ferr_uart_n <= ferr_uart_n + 1;
    if (frame_err_o != 2'b00) ferr_last <= frame_err_o;
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic drive(input int src, input logic v);
    if (src == 0) dbg_txd_i = v;
    else          uart_txd_i = v;
  endtask

  // Called just after a negedge; returns after a whole frame so frames can be chained back-to-back.
  task automatic send_byte(input int src, input logic [7:0] b, input bit bad_stop);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (i == 9 && bad_stop) begin
        drive(src, 1'b0);
        repeat (40) @(negedge clk50_i);
        drive(src, 1'b1);
        repeat (10) @(negedge clk50_i);
      end else begin
        drive(src, fr[i]);
        repeat (BIT_DIV) @(negedge clk50_i);
      end
    end
  endtask

  task automatic wait_idle(input string name, input int budget, output int t);
    bit done;
    done = 1'b0;
    t = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk50_i);
      if (exp_q.size() == 0 && !busy_o && !mon_busy) begin
        done = 1'b1;
        t = int'(cyc);
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: %0d bytes still expected, busy_o=%0b", name, exp_q.size(), busy_o);
    end
  endtask

  // Line monitor: decodes each output frame at mid-bit and checks it against the scoreboard.
  initial begin : monitor
    logic [9:0] got;
    bit aborted;
    forever begin
      @(negedge clk50_i);
      if (!rst && txd_o === 1'b0) begin
        mon_busy = 1'b1;
        fall_q.push_back(int'(cyc));
        aborted = 1'b0;
        got = '0;
        repeat (BIT_DIV / 2) @(negedge clk50_i);
        got[0] = txd_o;
        if (rst) aborted = 1'b1;
        for (int i = 1; i < 10; i++) begin
          repeat (BIT_DIV) @(negedge clk50_i);
          got[i] = txd_o;
          if (rst) aborted = 1'b1;
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_frame: got frame 0x%0h, expected no output", got);
          end else begin
            check("frame", got, {1'b1, exp_q.pop_front(), 1'b0});
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int t0, t_idle, n0;
    bit seen;

    // Reset state.
    repeat (5) @(negedge clk50_i);
    check("rst_txd", txd_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_ovf", {dbg_ovf_o, uart_ovf_o}, 0);
    check("rst_ferr", frame_err_o, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk50_i);

    // Single byte: 2 sync + half bit + 9 bits + push register + 2 = 480 cycles start-to-start.
    n0 = fall_q.size();
    exp_q.push_back(8'hA5);
    @(negedge clk50_i);
    t0 = int'(cyc);
    send_byte(0, 8'hA5, 1'b0);
    check("single_busy_mid", busy_o, 1);
    wait_idle("single", 2000, t_idle);
    check("single_nframes", fall_q.size(), n0 + 1);
    if (fall_q.size() > n0) check_range("single_latency", fall_q[n0] - t0, 477, 483);
    check("single_no_ferr", ferr_dbg_n + ferr_uart_n, 0);

    // Collision: both start bits in the same cycle; debug first, then application, no gap.
    n0 = fall_q.size();
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    @(negedge clk50_i);
    fork
      send_byte(0, 8'h3C, 1'b0);
      send_byte(1, 8'hC3, 1'b0);
    join
    check("collide_busy_mid", busy_o, 1);
    wait_idle("collide", 3000, t_idle);
    check("collide_nframes", fall_q.size(), n0 + 2);
    if (fall_q.size() > n0 + 1) begin
      check("collide_gap", fall_q[n0 + 1] - fall_q[n0], 10 * BIT_DIV);
      check_range("collide_busy_fall", t_idle - fall_q[n0 + 1], 10 * BIT_DIV, 10 * BIT_DIV + 1);
    end

    // Priority: debug queued during an application frame goes next, ahead of later application data.
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    @(negedge clk50_i);
    fork
      begin
        send_byte(1, 8'h11, 1'b0);
        send_byte(1, 8'h33, 1'b0);
      end
      begin
        repeat (10 * BIT_DIV) @(negedge clk50_i);
        send_byte(0, 8'h22, 1'b0);
      end
    join
    wait_idle("priority", 3000, t_idle);

    // Overflow: debug stream starves the output, 8 application bytes arrive, 4 fit.
    n0 = uart_ovf_n;
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h55);
    @(negedge clk50_i);
    fork
      for (int i = 0; i < 8; i++) send_byte(0, 8'(i), 1'b0);
      for (int i = 0; i < 8; i++) send_byte(1, 8'h55, 1'b0);
    join
    wait_idle("overflow", 8000, t_idle);
    check("overflow_uart_pulses", uart_ovf_n - n0, 4);
    check("overflow_dbg_pulses", dbg_ovf_n, 0);

    // Errors: a 20-cycle glitch is ignored; a low stop bit raises frame_err_o[1] only.
    n0 = fall_q.size();
    @(negedge clk50_i);
    uart_txd_i = 1'b0;
    repeat (20) @(negedge clk50_i);
    uart_txd_i = 1'b1;
    repeat (100) @(negedge clk50_i);
    check("glitch_no_frame", fall_q.size(), n0);
    check("glitch_no_ferr", ferr_uart_n, 0);
    check("glitch_idle", busy_o, 0);
    send_byte(1, 8'h7E, 1'b1);
    repeat (600) @(negedge clk50_i);
    check("ferr_uart_pulses", ferr_uart_n, 1);
    check("ferr_dbg_pulses", ferr_dbg_n, 0);
    check("ferr_value", ferr_last, 2'b10);
    check("ferr_no_frame", fall_q.size(), n0);
    check("ferr_idle", busy_o, 0);

    // Reset during output data bit 4 of 0x0F (bit value 0).
    n0 = fall_q.size();
    @(negedge clk50_i);
    send_byte(0, 8'h0F, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (fall_q.size() > n0) seen = 1'b1;
      else @(negedge clk50_i);
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL reset_frame_timeout: no output frame started");
    end else begin
      for (int i = 0; i < 1000 && int'(cyc) < fall_q[n0] + 5 * BIT_DIV + 25; i++) @(negedge clk50_i);
      check("reset_pre_txd", txd_o, 0);
      #3 rst = 1'b1;
      #1;
      check("reset_txd", txd_o, 1);
      check("reset_busy", busy_o, 0);
      repeat (100) @(negedge clk50_i);
      rst = 1'b0;
      repeat (5) @(negedge clk50_i);
      check("reset_after_idle", busy_o, 0);
    end
    exp_q.push_back(8'h5A);
    @(negedge clk50_i);
    send_byte(0, 8'h5A, 1'b0);
    wait_idle("after_reset", 2000, t_idle);
    check("final_dbg_ovf", dbg_ovf_n, 0);
    check("final_ferr_dbg", ferr_dbg_n, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
